// File: rtl/decode_stage.sv
// RV32I decode stage: registered decode with a main + skid entry for full-rate valid/ready flow.
// Optional macro DECODE_RV32M_EN adds decoding of the RV32M multiply/divide group.
module decode_stage #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_exe_fun,
    output logic [1:0]      out_op1,
    output logic [2:0]      out_op2,
    output logic [1:0]      out_wb_sel,
    output logic            out_mem_wen,
    output logic            out_rf_wen,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);

    // Control encodings shared with define.vh; every *_X code is zero so a cleared entry is a NOP.
    localparam logic [4:0] ALU_X    = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;
    localparam logic [4:0] ALU_SRL  = 5'd7;
    localparam logic [4:0] ALU_SRA  = 5'd8;
    localparam logic [4:0] ALU_SLT  = 5'd9;
    localparam logic [4:0] ALU_SLTU = 5'd10;
    localparam logic [4:0] BR_BEQ   = 5'd11;
    localparam logic [4:0] BR_BNE   = 5'd12;
    localparam logic [4:0] BR_BLT   = 5'd13;
    localparam logic [4:0] BR_BGE   = 5'd14;
    localparam logic [4:0] BR_BLTU  = 5'd15;
    localparam logic [4:0] BR_BGEU  = 5'd16;
    localparam logic [4:0] ALU_JALR = 5'd17;
`ifdef DECODE_RV32M_EN
    localparam logic [4:0] ALU_MUL    = 5'd18;
    localparam logic [4:0] ALU_MULH   = 5'd19;
    localparam logic [4:0] ALU_MULHSU = 5'd20;
    localparam logic [4:0] ALU_MULHU  = 5'd21;
    localparam logic [4:0] ALU_DIV    = 5'd22;
    localparam logic [4:0] ALU_DIVU   = 5'd23;
    localparam logic [4:0] ALU_REM    = 5'd24;
    localparam logic [4:0] ALU_REMU   = 5'd25;
`endif

    localparam logic [1:0] OP1_X   = 2'd0;
    localparam logic [1:0] OP1_RS1 = 2'd1;
    localparam logic [1:0] OP1_PC  = 2'd2;

    localparam logic [2:0] OP2_X   = 3'd0;
    localparam logic [2:0] OP2_RS2 = 3'd1;
    localparam logic [2:0] OP2_IMI = 3'd2;
    localparam logic [2:0] OP2_IMS = 3'd3;
    localparam logic [2:0] OP2_IMJ = 3'd4;
    localparam logic [2:0] OP2_IMU = 3'd5;

    localparam logic [1:0] WB_X   = 2'd0;
    localparam logic [1:0] WB_ALU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_PC  = 2'd3;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [4:0]      exe_fun;
        logic [1:0]      op1;
        logic [2:0]      op2;
        logic [1:0]      wb_sel;
        logic            mem_wen;
        logic            rf_wen;
        logic [2:0]      funct3;
        logic            illegal;
    } entry_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    entry_t   dec;
    entry_t   main_q;
    entry_t   skid_q;
    logic     main_valid;
    logic     skid_empty;
    logic     legal;
    logic     sh_lo;
    logic     sh_ar;
    imm_sel_t imm_sel;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = in_inst[14:12];
    assign f7 = in_inst[31:25];

    // RV64 shift amounts are six bits wide, so only inst[31:26] carries funct bits there.
    assign sh_lo = (XLEN == 64) ? (in_inst[31:26] == 6'b000000) : (in_inst[31:25] == 7'b0000000);
    assign sh_ar = (XLEN == 64) ? (in_inst[31:26] == 6'b010000) : (in_inst[31:25] == 7'b0100000);

    always_comb begin
        dec        = '0;
        dec.pc     = in_pc;
        dec.rs1    = in_inst[19:15];
        dec.rs2    = in_inst[24:20];
        dec.rd     = in_inst[11:7];
        dec.funct3 = f3;
        imm_sel    = IMM_NONE;
        legal      = 1'b1;
        case (in_inst[6:0])
            OPC_LUI: begin
                dec.exe_fun = ALU_ADD; dec.op1 = OP1_X; dec.op2 = OP2_IMU;
                dec.wb_sel = WB_ALU; dec.rf_wen = 1'b1; imm_sel = IMM_U;
            end
            OPC_AUIPC: begin
                dec.exe_fun = ALU_ADD; dec.op1 = OP1_PC; dec.op2 = OP2_IMU;
                dec.wb_sel = WB_ALU; dec.rf_wen = 1'b1; imm_sel = IMM_U;
            end
            OPC_JAL: begin
                dec.exe_fun = ALU_ADD; dec.op1 = OP1_PC; dec.op2 = OP2_IMJ;
                dec.wb_sel = WB_PC; dec.rf_wen = 1'b1; imm_sel = IMM_J;
            end
            OPC_JALR: begin
                dec.exe_fun = ALU_JALR; dec.op1 = OP1_RS1; dec.op2 = OP2_IMI;
                dec.wb_sel = WB_PC; dec.rf_wen = 1'b1; imm_sel = IMM_I;
                legal = (f3 == 3'b000);
            end
            OPC_BRANCH: begin
                dec.op1 = OP1_RS1; dec.op2 = OP2_RS2; imm_sel = IMM_B;
                case (f3)
                    3'b000:  dec.exe_fun = BR_BEQ;
                    3'b001:  dec.exe_fun = BR_BNE;
                    3'b100:  dec.exe_fun = BR_BLT;
                    3'b101:  dec.exe_fun = BR_BGE;
                    3'b110:  dec.exe_fun = BR_BLTU;
                    3'b111:  dec.exe_fun = BR_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.exe_fun = ALU_ADD; dec.op1 = OP1_RS1; dec.op2 = OP2_IMI;
                dec.wb_sel = WB_MEM; dec.rf_wen = 1'b1; imm_sel = IMM_I;
                legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            OPC_STORE: begin
                dec.exe_fun = ALU_ADD; dec.op1 = OP1_RS1; dec.op2 = OP2_IMS;
                dec.mem_wen = 1'b1; imm_sel = IMM_S;
                legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            OPC_OPIMM: begin
                dec.op1 = OP1_RS1; dec.op2 = OP2_IMI; dec.wb_sel = WB_ALU;
                dec.rf_wen = 1'b1; imm_sel = IMM_I;
                case (f3)
                    3'b000: dec.exe_fun = ALU_ADD;
                    3'b010: dec.exe_fun = ALU_SLT;
                    3'b011: dec.exe_fun = ALU_SLTU;
                    3'b100: dec.exe_fun = ALU_XOR;
                    3'b110: dec.exe_fun = ALU_OR;
                    3'b111: dec.exe_fun = ALU_AND;
                    3'b001: begin
                        dec.exe_fun = ALU_SLL;
                        legal = sh_lo;
                    end
                    default: begin
                        dec.exe_fun = sh_ar ? ALU_SRA : ALU_SRL;
                        legal = sh_lo || sh_ar;
                    end
                endcase
            end
            OPC_OP: begin
                dec.op1 = OP1_RS1; dec.op2 = OP2_RS2; dec.wb_sel = WB_ALU; dec.rf_wen = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  dec.exe_fun = ALU_ADD;
                            3'b001:  dec.exe_fun = ALU_SLL;
                            3'b010:  dec.exe_fun = ALU_SLT;
                            3'b011:  dec.exe_fun = ALU_SLTU;
                            3'b100:  dec.exe_fun = ALU_XOR;
                            3'b101:  dec.exe_fun = ALU_SRL;
                            3'b110:  dec.exe_fun = ALU_OR;
                            default: dec.exe_fun = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (f3)
                            3'b000:  dec.exe_fun = ALU_SUB;
                            3'b101:  dec.exe_fun = ALU_SRA;
                            default: legal = 1'b0;
                        endcase
                    end
`ifdef DECODE_RV32M_EN
                    7'b0000001: begin
                        case (f3)
                            3'b000:  dec.exe_fun = ALU_MUL;
                            3'b001:  dec.exe_fun = ALU_MULH;
                            3'b010:  dec.exe_fun = ALU_MULHSU;
                            3'b011:  dec.exe_fun = ALU_MULHU;
                            3'b100:  dec.exe_fun = ALU_DIV;
                            3'b101:  dec.exe_fun = ALU_DIVU;
                            3'b110:  dec.exe_fun = ALU_REM;
                            default: dec.exe_fun = ALU_REMU;
                        endcase
                    end
`endif
                    default: legal = 1'b0;
                endcase
            end
            OPC_MISC: ;  // FENCE: ordering is trivially met in-order, so it retires as a NOP
            default: legal = 1'b0;
        endcase

        case (imm_sel)
            IMM_I:   dec.imm = sext({{20{in_inst[31]}}, in_inst[31:20]});
            IMM_S:   dec.imm = sext({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
            IMM_B:   dec.imm = sext({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                     in_inst[30:25], in_inst[11:8], 1'b0});
            IMM_U:   dec.imm = sext({in_inst[31:12], 12'b0});
            IMM_J:   dec.imm = sext({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                     in_inst[20], in_inst[30:21], 1'b0});
            default: dec.imm = '0;
        endcase

        if (!legal) begin
            dec.imm     = '0;
            dec.exe_fun = ALU_X;
            dec.op1     = OP1_X;
            dec.op2     = OP2_X;
            dec.wb_sel  = WB_X;
            dec.mem_wen = 1'b0;
            dec.rf_wen  = 1'b0;
            dec.illegal = 1'b1;
        end
        if (dec.rd == 5'd0)
            dec.rf_wen = 1'b0;
    end

    // An empty entry is held as all-zero so the outputs read as a NOP whenever out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_empty <= 1'b1;
        end else if (flush) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_empty <= 1'b1;
        end else if (!main_valid || out_ready) begin
            if (!skid_empty) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_q     <= '0;
                skid_empty <= 1'b1;
            end else if (in_valid) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_q     <= '0;
                main_valid <= 1'b0;
            end
        end else if (in_valid && skid_empty) begin
            skid_q     <= dec;
            skid_empty <= 1'b0;
        end
    end

    assign in_ready    = skid_empty;
    assign out_valid   = main_valid;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_exe_fun = main_q.exe_fun;
    assign out_op1     = main_q.op1;
    assign out_op2     = main_q.op2;
    assign out_wb_sel  = main_q.wb_sel;
    assign out_mem_wen = main_q.mem_wen;
    assign out_rf_wen  = main_q.rf_wen;
    assign out_funct3  = main_q.funct3;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed scoreboard bench for decode_stage (XLEN=32 instance plus an XLEN=64 instance in lockstep).
module tb_decode_stage;

    localparam logic [4:0] ALU_X = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_SRA = 5'd8;
    localparam logic [4:0] BR_BEQ = 5'd11;
`ifdef DECODE_RV32M_EN
    localparam logic [4:0] ALU_MUL = 5'd18;
`endif
    localparam logic [1:0] OP1_X = 2'd0, OP1_RS1 = 2'd1, OP1_PC = 2'd2;
    localparam logic [2:0] OP2_X = 3'd0, OP2_RS2 = 3'd1, OP2_IMI = 3'd2, OP2_IMS = 3'd3;
    localparam logic [2:0] OP2_IMJ = 3'd4, OP2_IMU = 3'd5;
    localparam logic [1:0] WB_X = 2'd0, WB_ALU = 2'd1, WB_MEM = 2'd2, WB_PC = 2'd3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd, rs1, rs2, exe;
        logic [1:0]  op1;
        logic [2:0]  op2;
        logic [1:0]  wb;
        logic        mem, rf;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_inst = '0, in_pc = '0;
    logic in_ready, out_valid, out_mem_wen, out_rf_wen, out_illegal;
    logic [31:0] out_pc, out_imm;
    logic [4:0] out_rs1, out_rs2, out_rd, out_exe_fun;
    logic [1:0] out_op1, out_wb_sel;
    logic [2:0] out_op2, out_funct3;

    logic in_ready64, out_valid64, out_mem_wen64, out_rf_wen64, out_illegal64;
    logic [31:0] out_pc64;
    logic [63:0] out_imm64;
    logic [4:0] out_rs1_64, out_rs2_64, out_rd64, out_exe_fun64;
    logic [1:0] out_op1_64, out_wb_sel64;
    logic [2:0] out_op2_64, out_funct3_64;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_assert = 0, n_fail = 0, cyc = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_exe_fun(out_exe_fun), .out_op1(out_op1), .out_op2(out_op2), .out_wb_sel(out_wb_sel),
        .out_mem_wen(out_mem_wen), .out_rf_wen(out_rf_wen), .out_funct3(out_funct3),
        .out_illegal(out_illegal));

    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
        .out_pc(out_pc64), .out_imm(out_imm64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
        .out_rd(out_rd64), .out_exe_fun(out_exe_fun64), .out_op1(out_op1_64), .out_op2(out_op2_64),
        .out_wb_sel(out_wb_sel64), .out_mem_wen(out_mem_wen64), .out_rf_wen(out_rf_wen64),
        .out_funct3(out_funct3_64), .out_illegal(out_illegal64));

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] exe, input logic [1:0] op1, input logic [2:0] op2,
                                input logic [1:0] wb, input logic mem, input logic rf,
                                input logic [2:0] f3, input logic ill);
        exp_t e;
        e.pc = pc; e.imm = imm; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.exe = exe;
        e.op1 = op1; e.op2 = op2; e.wb = wb; e.mem = mem; e.rf = rf; e.f3 = f3; e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] addi_inst(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic exp_t addi_e(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] imm);
        return mk(pc, {27'd0, imm}, rd, 5'd0, imm, ALU_ADD, OP1_RS1, OP2_IMI, WB_ALU,
                  1'b0, rd != 5'd0, 3'b000, 1'b0);
    endfunction

    function automatic exp_t illegal_e(input logic [31:0] pc, input logic [31:0] inst);
        return mk(pc, 32'd0, inst[11:7], inst[19:15], inst[24:20], ALU_X, OP1_X, OP2_X, WB_X,
                  1'b0, 1'b0, inst[14:12], 1'b1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        n_assert++;
        assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_extra_output observed=pc 0x%0h expected=no output", out_pc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pc", out_pc, e.pc);
            chk("imm", out_imm, e.imm);
            chk("rd", out_rd, e.rd);
            chk("rs1", out_rs1, e.rs1);
            chk("rs2", out_rs2, e.rs2);
            chk("exe_fun", out_exe_fun, e.exe);
            chk("op1", out_op1, e.op1);
            chk("op2", out_op2, e.op2);
            chk("wb_sel", out_wb_sel, e.wb);
            chk("mem_wen", out_mem_wen, e.mem);
            chk("rf_wen", out_rf_wen, e.rf);
            chk("funct3", out_funct3, e.f3);
            chk("illegal", out_illegal, e.ill);
        end
    endtask

    // One clock: sample at the falling edge, update the scoreboard, return just after the rising edge.
    task automatic cycle(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready && !flush;
        if (!flush && out_valid && out_ready) compare_out();
        if (acc) sb.push_back(cur_exp);
        if (flush) sb.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick();
        bit a;
        cycle(a);
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
        bit acc = 0;
        in_valid = 1; in_inst = inst; in_pc = pc; cur_exp = e;
        for (int i = 0; i < 20 && !acc; i++) cycle(acc);
        in_valid = 0;
        if (!acc) chk("send_timeout", {63'd0, acc}, 64'd1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int   start;
        bit   acc;
        exp_t e_mul;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_exe_fun", out_exe_fun, ALU_X);
        chk("rst_rf_wen", out_rf_wen, 0);
        rst = 0;
        @(posedge clk); #1;

        // ADDI: one-cycle latency, then bubble reads as NOP
        out_ready = 1;
        send(32'h00500093, 32'h100, addi_e(32'h100, 5'd1, 5'd5));
        chk("addi_latency_valid", out_valid, 1);
        tick();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_exe_nop", out_exe_fun, ALU_X);
        chk("idle_wb_nop", out_wb_sel, WB_X);

        // BEQ with negative B immediate
        send(32'hFE000EE3, 32'h104, mk(32'h104, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0, BR_BEQ,
                                       OP1_RS1, OP2_RS2, WB_X, 1'b0, 1'b0, 3'b000, 1'b0));
        tick();

        // LUI: check sign extension on the 64-bit instance too
        send(32'h800002B7, 32'h108, mk(32'h108, 32'h80000000, 5'd5, 5'd0, 5'd0, ALU_ADD,
                                       OP1_X, OP2_IMU, WB_ALU, 1'b0, 1'b1, 3'b000, 1'b0));
        chk("lui_imm64", out_imm64, 64'hFFFFFFFF80000000);
        chk("lui_rd64", out_rd64, 5'd5);
        tick();

        // MUL: legal only when the M extension is built in
`ifdef DECODE_RV32M_EN
        e_mul = mk(32'h10C, 32'd0, 5'd3, 5'd1, 5'd2, ALU_MUL, OP1_RS1, OP2_RS2, WB_ALU,
                   1'b0, 1'b1, 3'b000, 1'b0);
`else
        e_mul = illegal_e(32'h10C, 32'h022081B3);
`endif
        send(32'h022081B3, 32'h10C, e_mul);
        tick();

        // Undefined opcode still flows through the handshake
        send(32'h0000007F, 32'h110, illegal_e(32'h110, 32'h0000007F));
        tick();

        // SLLI with inst[25]=1: illegal at XLEN=32, a legal 33-bit shift at XLEN=64
        send(32'h02101093, 32'h114, illegal_e(32'h114, 32'h02101093));
        chk("slli64_legal", out_illegal64, 0);
        tick();

        // Back-to-back stream: one accept per cycle
        start = cyc;
        send(32'h0020A423, 32'h200, mk(32'h200, 32'd8, 5'd8, 5'd1, 5'd2, ALU_ADD, OP1_RS1,
                                       OP2_IMS, WB_X, 1'b1, 1'b0, 3'b010, 1'b0));
        send(32'hFFC12183, 32'h204, mk(32'h204, 32'hFFFFFFFC, 5'd3, 5'd2, 5'd28, ALU_ADD, OP1_RS1,
                                       OP2_IMI, WB_MEM, 1'b0, 1'b1, 3'b010, 1'b0));
        send(32'h010000EF, 32'h208, mk(32'h208, 32'd16, 5'd1, 5'd0, 5'd16, ALU_ADD, OP1_PC,
                                       OP2_IMJ, WB_PC, 1'b0, 1'b1, 3'b000, 1'b0));
        send(32'h407302B3, 32'h20C, mk(32'h20C, 32'd0, 5'd5, 5'd6, 5'd7, ALU_SUB, OP1_RS1,
                                       OP2_RS2, WB_ALU, 1'b0, 1'b1, 3'b000, 1'b0));
        send(32'h40325213, 32'h210, mk(32'h210, 32'h403, 5'd4, 5'd4, 5'd3, ALU_SRA, OP1_RS1,
                                       OP2_IMI, WB_ALU, 1'b0, 1'b1, 3'b101, 1'b0));
        send(addi_inst(5'd0, 12'd1), 32'h214, addi_e(32'h214, 5'd0, 5'd1));
        send(32'h0FF0000F, 32'h218, mk(32'h218, 32'd0, 5'd0, 5'd0, 5'd31, ALU_X, OP1_X,
                                       OP2_X, WB_X, 1'b0, 1'b0, 3'b000, 1'b0));
        send(32'h00002063, 32'h21C, illegal_e(32'h21C, 32'h00002063));
        chk("throughput_cycles", cyc - start, 8);
        wait_empty();

        // Backpressure: first held, second in skid, third refused until release
        out_ready = 0;
        send(addi_inst(5'd1, 12'd1), 32'h300, addi_e(32'h300, 5'd1, 5'd1));
        send(addi_inst(5'd2, 12'd2), 32'h304, addi_e(32'h304, 5'd2, 5'd2));
        chk("bp_in_ready_low", in_ready, 0);
        in_valid = 1; in_inst = addi_inst(5'd3, 12'd3); in_pc = 32'h308;
        cur_exp = addi_e(32'h308, 5'd3, 5'd3);
        cycle(acc);
        chk("bp_third_refused", acc, 0);
        cycle(acc);
        chk("bp_stable_pc", out_pc, 32'h300);
        chk("bp_stable_imm", out_imm, 32'd1);
        out_ready = 1;
        cycle(acc);
        chk("bp_release_no_accept", acc, 0);
        chk("bp_in_ready_return", in_ready, 1);
        cycle(acc);
        chk("bp_third_accepted", acc, 1);
        in_valid = 0;
        wait_empty();

        // Flush with main+skid full and a pending offer
        out_ready = 0;
        send(addi_inst(5'd1, 12'd4), 32'h400, addi_e(32'h400, 5'd1, 5'd4));
        send(addi_inst(5'd2, 12'd5), 32'h404, addi_e(32'h404, 5'd2, 5'd5));
        in_valid = 1; in_inst = addi_inst(5'd3, 12'd6); in_pc = 32'h408; flush = 1;
        tick();
        flush = 0; in_valid = 0;
        chk("flush_full_out_valid", out_valid, 0);
        chk("flush_full_in_ready", in_ready, 1);

        // Flush overrides a simultaneous accept
        send(addi_inst(5'd1, 12'd7), 32'h410, addi_e(32'h410, 5'd1, 5'd7));
        in_valid = 1; in_inst = addi_inst(5'd2, 12'd8); in_pc = 32'h414; flush = 1;
        tick();
        flush = 0; in_valid = 0; out_ready = 1;
        chk("flush_accept_out_valid", out_valid, 0);
        tick();
        tick();
        chk("flush_nothing_emerges", out_valid, 0);

        // Asynchronous reset mid-stall
        out_ready = 0;
        send(addi_inst(5'd1, 12'd9), 32'h500, addi_e(32'h500, 5'd1, 5'd9));
        send(addi_inst(5'd2, 12'd10), 32'h504, addi_e(32'h504, 5'd2, 5'd10));
        #2 rst = 1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_pc", out_pc, 0);
        sb.delete();
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        out_ready = 1;
        send(32'h00500093, 32'h600, addi_e(32'h600, 5'd1, 5'd5));
        chk("post_rst_latency_valid", out_valid, 1);
        wait_empty();
        tick();
        chk("final_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, immediate/datapath width, legal values 32 or 64.
REQ-002 Parameter PC_W, default 32, program-counter width carried alongside each instruction.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  32  RV32I instruction word.
- in_pc  in  PC_W  address of in_inst.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_pc  out  PC_W  PC of the decoded entry.
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  5 each  register addresses taken from inst[19:15], inst[24:20] and inst[11:7].
- out_exe_fun  out  5  ALU/branch function; encoding per define.vh.
- out_op1  out  2  operand-1 select.
- out_op2  out  3  operand-2 select.
- out_wb_sel  out  2  write-back select.
- out_mem_wen  out  1  store enable.
- out_rf_wen  out  1  register-file write enable.
- out_funct3  out  3  memory access size/sign, passed through from inst[14:12].
- out_illegal  out  1  unsupported encoding.

Function
REQ-004 Decoding SHALL be registered, with exactly one cycle of latency from an accepted input (in_valid & in_ready) to out_valid.
REQ-005 The stage SHALL hold two entries (main plus skid); in_ready SHALL be a register equal to "skid entry empty".
REQ-006 When out_valid & !out_ready, out_* SHALL stay stable; an input accepted in that cycle SHALL go into the skid entry.
REQ-007 When out_ready is asserted with the skid entry full, the skid entry SHALL move to main on that edge and in_ready SHALL return to 1.
REQ-008 Simultaneous accept and drain with the skid entry empty SHALL load main directly, with no bubble; sustained throughput SHALL be 1 per cycle.
REQ-009 Flush SHALL clear both entries on the next edge (out_valid=0, in_ready=1) and SHALL override any simultaneous accept.
REQ-010 Immediate formats U/J/I/B/S SHALL be sign-extended from inst[31] to XLEN; R-type and illegal encodings SHALL produce out_imm=0.
REQ-011 The following SHALL decode as legal:
- LUI, AUIPC, JAL, JALR.
- BRANCH with funct3 in {000, 001, 100, 101, 110, 111}.
- LOAD with funct3 in {000, 001, 010, 100, 101}: ALU_ADD, WB_MEM, rf_wen=1.
- STORE with funct3 in {000, 001, 010}: ALU_ADD, OP2_IMS, mem_wen=1.
- OP-IMM and OP, with funct7 checked for shifts and ADD/SUB.
- MISC-MEM (FENCE) as a NOP with out_illegal=0.
REQ-012 Any other encoding SHALL produce out_illegal=1, ALU_X/OP1_X/OP2_X/WB_X, and mem_wen=0, rf_wen=0; the entry SHALL still flow through the handshake.
REQ-013 out_rf_wen SHALL be forced to 0 when rd=0.
REQ-014 SLLI/SRLI/SRAI SHALL check inst[31:26] (six bits) when XLEN=64 and inst[31:25] when XLEN=32.
REQ-015 Control outputs SHALL be the all-X/zero NOP encoding whenever out_valid=0.

Reset
REQ-016 rst SHALL asynchronously set out_valid=0, in_ready=1, both entries empty, all out_* data=0, and control outputs to the NOP encoding.
REQ-017 An assertion of rst mid-stall SHALL discard held entries; the first accept after deassertion SHALL behave as after power-up.

Configuration
REQ-018 With macro DECODE_RV32M_EN defined, OP with funct7=0000001 SHALL decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to their define.vh ALU codes, with WB_ALU and rf_wen=1.
REQ-019 Without DECODE_RV32M_EN, those encodings SHALL decode as illegal per REQ-012.

Verification
REQ-020 ADDI: 0x00500093, PC=0x100, out_ready=1 -> next cycle out_valid=1, out_imm=5, rd=1, ALU_ADD, OP2_IMI, rf_wen=1, WB_ALU, out_pc=0x100.
REQ-021 BEQ: 0xFE000EE3 -> out_imm=0xFFFFFFFC, BR_BEQ, rf_wen=0, mem_wen=0.
REQ-022 Backpressure: hold out_ready=0 and offer 3 back-to-back instructions -> first held stable, second in skid, in_ready=0, third not accepted; release -> all three emerge in order with no loss or duplication.
REQ-023 Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and nothing from that cycle emerges.
REQ-024 MUL: 0x022081B3 -> out_illegal=0 and ALU MUL code with the macro; out_illegal=1 and rf_wen=0 without it.
REQ-025 LUI: XLEN=64 with 0x800002B7 -> out_imm=0xFFFFFFFF80000000 and rd=5; undefined opcode 0x0000007F -> out_illegal=1.
